// File: rtl/rv32i_imem_encoder_pkg.sv
// rv32i_imem_encoder_pkg: instruction kinds, RV32I opcodes, immediate limits and the field bundle type
package rv32i_imem_encoder_pkg;

    localparam logic [3:0] KIND_R      = 4'd0;
    localparam logic [3:0] KIND_I      = 4'd1;
    localparam logic [3:0] KIND_LUI    = 4'd2;
    localparam logic [3:0] KIND_AUIPC  = 4'd3;
    localparam logic [3:0] KIND_LOAD   = 4'd4;
    localparam logic [3:0] KIND_STORE  = 4'd5;
    localparam logic [3:0] KIND_BRANCH = 4'd6;
    localparam logic [3:0] KIND_JAL    = 4'd7;
    localparam logic [3:0] KIND_JALR   = 4'd8;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int SHAMT_MAX = 31;
    localparam int IMMB_MIN  = -4096;
    localparam int IMMB_MAX  = 4094;
    localparam int IMMJ_MIN  = -(1 << 20);
    localparam int IMMJ_MAX  = (1 << 20) - 2;

    typedef struct packed {
        logic [3:0]  kind;
        logic [2:0]  funct3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } fields_t;

    function automatic logic in_range(logic [31:0] v, int lo, int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

endpackage

// File: rtl/rv32i_imem_encoder_pack.sv
// rv32i_field_pack: packs one decoded field bundle into an RV32I word and flags whether it is encodable
module rv32i_field_pack
    import rv32i_imem_encoder_pkg::*;
(
    input  fields_t     f_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    logic [31:0] imm;
    logic [2:0]  f3;
    logic        is_shift;
    logic        r_alt;

    assign imm      = f_i.imm;
    assign f3       = f_i.funct3;
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
    assign r_alt    = f_i.alt && ((f3 == 3'b000) || (f3 == 3'b101));

    // Format selection and legality per instruction kind; undefined kinds stay illegal
    always_comb begin
        word_o  = '0;
        legal_o = 1'b0;
        case (f_i.kind)
            KIND_R: begin
                word_o  = {1'b0, r_alt, 5'b0, f_i.rs2, f_i.rs1, f3, f_i.rd, OP_R};
                legal_o = 1'b1;
            end
            KIND_I: begin
                word_o  = is_shift
                        ? {1'b0, (f3 == 3'b101) && f_i.alt, 5'b0, imm[4:0], f_i.rs1, f3, f_i.rd, OP_IMM}
                        : {imm[11:0], f_i.rs1, f3, f_i.rd, OP_IMM};
                legal_o = is_shift ? in_range(imm, 0, SHAMT_MAX) : in_range(imm, IMM12_MIN, IMM12_MAX);
            end
            KIND_LUI: begin
                word_o  = {imm[31:12], f_i.rd, OP_LUI};
                legal_o = (imm[11:0] == 12'd0);
            end
            KIND_AUIPC: begin
                word_o  = {imm[31:12], f_i.rd, OP_AUIPC};
                legal_o = (imm[11:0] == 12'd0);
            end
            KIND_LOAD: begin
                word_o  = {imm[11:0], f_i.rs1, f3, f_i.rd, OP_LOAD};
                legal_o = in_range(imm, IMM12_MIN, IMM12_MAX)
                       && (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            end
            KIND_STORE: begin
                word_o  = {imm[11:5], f_i.rs2, f_i.rs1, f3, imm[4:0], OP_STORE};
                legal_o = in_range(imm, IMM12_MIN, IMM12_MAX) && (f3 <= 3'b010);
            end
            KIND_BRANCH: begin
                word_o  = {imm[12], imm[10:5], f_i.rs2, f_i.rs1, f3, imm[4:1], imm[11], OP_BRANCH};
                legal_o = !imm[0] && in_range(imm, IMMB_MIN, IMMB_MAX)
                       && (f3 != 3'b010) && (f3 != 3'b011);
            end
            KIND_JAL: begin
                word_o  = {imm[20], imm[10:1], imm[11], imm[19:12], f_i.rd, OP_JAL};
                legal_o = !imm[0] && in_range(imm, IMMJ_MIN, IMMJ_MAX);
            end
            KIND_JALR: begin
                word_o  = {imm[11:0], f_i.rs1, 3'b000, f_i.rd, OP_JALR};
                legal_o = in_range(imm, IMM12_MIN, IMM12_MAX);
            end
            default: begin
                word_o  = '0;
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rv32i_imem_encoder.sv
// rv32i_imem_encoder: two-stage field-to-word encoder writing legal RV32I words sequentially into imem
module rv32i_imem_encoder
    import rv32i_imem_encoder_pkg::*;
#(
    parameter int AW    = 12,
    parameter int BASE  = 0,
    parameter int DEPTH = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_kind,
    input  logic [2:0]    in_funct3,
    input  logic          in_alt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [31:0]   in_imm,
    output logic          imem_we,
    input  logic          imem_gnt,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          err,
    output logic [15:0]   err_count,
    output logic [15:0]   word_count
);

    localparam logic [AW-1:0] BASE_A = AW'(BASE);
    localparam logic [31:0]   END_A  = 32'(BASE + 4 * DEPTH);

    fields_t       s1_q, s1_d;
    logic          s1_valid_q, s1_valid_d;
    logic          s2_valid_q, s2_valid_d;
    logic [31:0]   s2_word_q, s2_word_d;
    logic          s2_legal_q, s2_legal_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   err_count_q, err_count_d;
    logic [15:0]   word_count_q, word_count_d;

    logic [31:0] pack_word;
    logic        pack_legal;
    logic        s2_drain, s1_adv, accept, wr;
    logic [31:0] addr_inc;

    rv32i_field_pack u_pack (
        .f_i     (s1_q),
        .word_o  (pack_word),
        .legal_o (pack_legal)
    );

    // An illegal word leaves S2 by itself; a legal one waits for the grant
    assign s2_drain   = s2_valid_q && (!s2_legal_q || imem_gnt);
    assign s1_adv     = !s2_valid_q || s2_drain;
    assign in_ready   = !rst && !clear && (!s1_valid_q || s1_adv);
    assign accept     = in_valid && in_ready;
    assign imem_we    = !rst && !clear && s2_valid_q && s2_legal_q;
    assign err        = !rst && !clear && s2_valid_q && !s2_legal_q;
    assign wr         = imem_we && imem_gnt;
    assign addr_inc   = 32'(addr_q) + 32'd4;
    assign imem_addr  = addr_q;
    assign imem_wdata = s2_word_q;
    assign err_count  = err_count_q;
    assign word_count = word_count_q;

    // Next-state for both pipeline stages, the write address and the counters
    always_comb begin
        s1_valid_d   = clear ? 1'b0 : (accept || (s1_valid_q && !s1_adv));
        s1_d         = accept ? {in_kind, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm} : s1_q;
        s2_valid_d   = clear ? 1'b0 : (s1_adv ? s1_valid_q : s2_valid_q);
        s2_word_d    = (s1_adv && s1_valid_q) ? pack_word : s2_word_q;
        s2_legal_d   = (s1_adv && s1_valid_q) ? pack_legal : s2_legal_q;
        addr_d       = clear ? BASE_A : wr ? ((addr_inc == END_A) ? BASE_A : addr_inc[AW-1:0]) : addr_q;
        err_count_d  = (err && (err_count_q != 16'hFFFF)) ? err_count_q + 16'd1 : err_count_q;
        word_count_d = clear ? 16'd0 : wr ? word_count_q + 16'd1 : word_count_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q         <= '0;
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_word_q    <= '0;
            s2_legal_q   <= 1'b0;
            addr_q       <= BASE_A;
            err_count_q  <= '0;
            word_count_q <= '0;
        end else begin
            s1_q         <= s1_d;
            s1_valid_q   <= s1_valid_d;
            s2_valid_q   <= s2_valid_d;
            s2_word_q    <= s2_word_d;
            s2_legal_q   <= s2_legal_d;
            addr_q       <= addr_d;
            err_count_q  <= err_count_d;
            word_count_q <= word_count_d;
        end
    end

endmodule
